// File: rtl/scic_io_port.sv
// Memory-mapped I/O responder for the SCIC core: debounced switch inputs, latched LEDs
// with per-bit blink mask, and a pollable switch-change status bit.
module scic_io_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BLINK_DIV       = 8,
  parameter logic [3:0]  LED_RESET       = 4'h0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] io_addr,
  input  logic [3:0] io_wdata,
  input  logic       io_we,
  input  logic       io_re,
  output logic [3:0] io_rdata,
  output logic       io_ack,
  input  logic [3:0] switches,
  output logic [3:0] LEDs
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BW = (BLINK_DIV < 2) ? 1 : $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [3:0]    sync1, sync2, cand, debounced;
  logic [CW-1:0] cnt;
  logic          changed;
  logic [3:0]    led_reg, blink_mask;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [3:0]    rdata_q;
  logic [3:0]    rd_next;
  logic          stable, rd_only, commit, set_changed, clr_changed;

  assign stable  = (cand == debounced);
  assign rd_only = io_re && !io_we;
  assign commit  = (sync2 == cand) && (cnt >= CNT_MAX);
  assign set_changed = commit && (cand != debounced);
  assign clr_changed = (rd_only && io_addr == 2'd0) ||
                       (io_we && io_addr == 2'd2 && io_wdata[0]);

  always_comb begin
    rd_next = '0;
    if (rd_only) begin
      case (io_addr)
        2'd0: rd_next = debounced;
        2'd1: rd_next = led_reg;
        2'd2: rd_next = {2'b00, stable, changed};
        2'd3: rd_next = blink_mask;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_ack     <= 1'b0;
      rdata_q    <= '0;
      led_reg    <= LED_RESET;
      blink_mask <= '0;
    end else begin
      io_ack  <= io_re || io_we;
      rdata_q <= rd_next;
      if (io_we) begin
        case (io_addr)
          2'd1:    led_reg    <= io_wdata;
          2'd3:    blink_mask <= io_wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      cand      <= '0;
      cnt       <= '0;
      debounced <= '0;
      changed   <= 1'b0;
    end else begin
      sync1 <= switches;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else begin
        debounced <= cand;
      end
      // A new debounced value outranks a same-edge software clear.
      if (set_changed)      changed <= 1'b1;
      else if (clr_changed) changed <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign io_rdata = io_ack ? rdata_q : 4'h0;
  assign LEDs     = led_reg & ~(blink_mask & {4{phase}});

endmodule

// File: tb/tb_scic_io_port.sv
// Scoreboard bench for scic_io_port: stimulus queues expected acks, a negedge monitor checks them.
module tb_scic_io_port;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] io_addr = '0;
  logic [3:0] io_wdata = '0;
  logic       io_we = 1'b0;
  logic       io_re = 1'b0;
  logic [3:0] io_rdata;
  logic       io_ack;
  logic [3:0] switches = '0;
  logic [3:0] LEDs;

  typedef struct {
    int         cyc;
    logic [3:0] data;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   rel = 0;
  int   passed = 0;
  int   total = 0;

  scic_io_port #(.DEBOUNCE_CYCLES(4), .BLINK_DIV(8), .LED_RESET(4'h0)) dut (
    .clock(clock), .reset(reset), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata), .io_ack(io_ack),
    .switches(switches), .LEDs(LEDs)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Monitor: every ack must match the oldest queued request, exactly one cycle after issue.
  always @(negedge clock) begin
    exp_t e;
    if (io_ack === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_ack: got ack rdata=%h at cyc %0d want no ack", io_rdata, cyc);
      end else begin
        e = sb.pop_front();
        if (e.cyc == cyc && io_rdata === e.data) passed++;
        else $display("FAIL %s: got rdata=%h at cyc %0d want %h at cyc %0d",
                      e.name, io_rdata, cyc, e.data, e.cyc);
      end
    end else begin
      if (io_rdata !== 4'h0) begin
        total++;
        $display("FAIL idle_rdata: got %h want 0", io_rdata);
      end
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        total++;
        $display("FAIL %s: got no ack at cyc %0d want ack data %h", e.name, cyc, e.data);
      end
    end
  end

  task automatic req(input string name, input logic [1:0] a, input logic [3:0] wd,
                     input logic we, input logic re, input logic [3:0] exp);
    exp_t e;
    @(negedge clock);
    io_addr = a; io_wdata = wd; io_we = we; io_re = re;
    e.cyc = cyc + 1; e.data = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      io_we = 1'b0; io_re = 1'b0; io_wdata = '0; io_addr = '0;
    end
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [3:0] exp);
    req(name, a, 4'h0, 1'b0, 1'b1, exp);
    idle(1);
  endtask

  task automatic wr(input string name, input logic [1:0] a, input logic [3:0] d);
    req(name, a, d, 1'b1, 1'b0, 4'h0);
    idle(1);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    rel = cyc;
  endtask

  logic [3:0] status_seq [8];

  initial begin
    status_seq = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011};

    // 1. reset
    repeat (3) @(negedge clock);
    check("reset_leds", LEDs, 4'h0);
    check("reset_ack", {3'b0, io_ack}, 4'h0);
    check("reset_rdata", io_rdata, 4'h0);
    release_reset();
    rd("status_after_reset", 2'd2, 4'b0010);

    // 2. LED write then back-to-back read
    req("led_write", 2'd1, 4'hA, 1'b1, 1'b0, 4'h0);
    req("led_read", 2'd1, 4'h0, 1'b0, 1'b1, 4'hA);
    idle(1);
    check("leds_after_write", LEDs, 4'hA);
    wr("sw_write_ignored", 2'd0, 4'hF);

    // 3. switch change: STATUS each edge tracks the debounce pipeline
    @(negedge clock);
    switches = 4'h5;
    for (int i = 0; i < 8; i++) req($sformatf("status_timing_%0d", i), 2'd2, 4'h0, 1'b0, 1'b1, status_seq[i]);
    idle(1);
    rd("sw_read_5", 2'd0, 4'h5);
    rd("status_cleared", 2'd2, 4'b0010);

    // return to 0, clear via STATUS W1C
    @(negedge clock);
    switches = 4'h0;
    idle(12);
    rd("status_back_to_0", 2'd2, 4'b0011);
    wr("status_w1c", 2'd2, 4'h1);
    rd("status_after_w1c", 2'd2, 4'b0010);

    // 4. short glitch
    @(negedge clock);
    switches = 4'hF;
    idle(3);
    switches = 4'h0;
    idle(12);
    rd("glitch_status", 2'd2, 4'b0010);
    rd("glitch_sw", 2'd0, 4'h0);

    // 5. blink
    wr("led_write_f", 2'd1, 4'hF);
    wr("blink_write", 2'd3, 4'h3);
    rd("blink_read", 2'd3, 4'h3);
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      check($sformatf("blink_%0d", i), LEDs, (((cyc - rel) / 8) % 2 == 1) ? 4'hC : 4'hF);
    end
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check("leds_async_reset", LEDs, 4'h0);
    idle(2);
    release_reset();
    rd("blink_after_reset", 2'd3, 4'h0);

    // 6. same-edge conflicts
    req("we_re_led", 2'd1, 4'h6, 1'b1, 1'b1, 4'h0);
    idle(1);
    check("leds_we_re", LEDs, 4'h6);
    rd("led_read_6", 2'd1, 4'h6);
    @(negedge clock);
    switches = 4'h9;
    for (int i = 0; i < 6; i++) req($sformatf("conflict_status_%0d", i), 2'd2, 4'h0, 1'b0, 1'b1, status_seq[i]);
    req("conflict_sw_read", 2'd0, 4'h0, 1'b0, 1'b1, 4'h0);
    req("conflict_changed_wins", 2'd2, 4'h0, 1'b0, 1'b1, 4'b0011);
    idle(1);
    rd("sw_read_9", 2'd0, 4'h9);
    rd("status_final", 2'd2, 4'b0010);

    idle(3);
    if (sb.size() != 0) begin
      total++;
      $display("FAIL pending_acks: got %0d outstanding want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
